// File: rtl/mc_pkg.sv
// Shared state codes and opcode/funct constants for the multi-cycle core.
// Used by the next-state sequencer and the control decoder alike.
package mc_pkg;

  localparam logic [4:0] S0  = 5'd0;
  localparam logic [4:0] S1  = 5'd1;
  localparam logic [4:0] S2  = 5'd2;
  localparam logic [4:0] S3  = 5'd3;
  localparam logic [4:0] S4  = 5'd4;
  localparam logic [4:0] S5  = 5'd5;
  localparam logic [4:0] S6  = 5'd6;
  localparam logic [4:0] S7  = 5'd7;
  localparam logic [4:0] S8  = 5'd8;
  localparam logic [4:0] S9  = 5'd9;
  localparam logic [4:0] S10 = 5'd10;
  localparam logic [4:0] S11 = 5'd11;
  localparam logic [4:0] S12 = 5'd12;
  localparam logic [4:0] S13 = 5'd13;
  localparam logic [4:0] S14 = 5'd14;
  localparam logic [4:0] S15 = 5'd15;
  localparam logic [4:0] S16 = 5'd16;
  localparam logic [4:0] S17 = 5'd17;
  localparam logic [4:0] S18 = 5'd18;
  localparam logic [4:0] S19 = 5'd19;
  localparam logic [4:0] S20 = 5'd20;
  localparam logic [4:0] S21 = 5'd21;

  // Internal encoding of the idle phase; never driven onto state.
  localparam logic [4:0] IDLE_CODE = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;

  typedef enum logic [4:0] {
    PH_S0  = S0,  PH_S1  = S1,  PH_S2  = S2,
    PH_S3  = S3,  PH_S4  = S4,  PH_S5  = S5,
    PH_S6  = S6,  PH_S7  = S7,  PH_S8  = S8,
    PH_S9  = S9,  PH_S10 = S10, PH_S11 = S11,
    PH_S12 = S12, PH_S13 = S13, PH_S14 = S14,
    PH_S15 = S15, PH_S16 = S16, PH_S17 = S17,
    PH_S18 = S18, PH_S19 = S19,
    PH_IDLE = IDLE_CODE
  } phase_t;

  function automatic logic is_final(phase_t p);
    return p inside {PH_S4, PH_S5, PH_S17, PH_S7,
                     PH_S12, PH_S18, PH_S8, PH_S15,
                     PH_S9};
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-phase logic: (phase, op, funct, go) -> next phase.
// Ports: phase, op, funct, go in; next, illegal, last out.
module mc_next_state
  import mc_pkg::*;
(
  input  phase_t     phase,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       go,
  output phase_t     next,
  output logic       illegal,
  output logic       last
);

  always_comb begin
    next    = PH_IDLE;
    illegal = 1'b0;
    last    = is_final(phase);
    case (phase)
      PH_IDLE: next = go ? PH_S0 : PH_IDLE;
      PH_S0:   next = PH_S1;
      PH_S1: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_LB),
          (op == OP_SW),
          (op == OP_SB):  next = PH_S2;
          (op == OP_RTYPE && funct == F_ADDU):
            next = PH_S6;
          (op == OP_RTYPE && funct == F_SUBU):
            next = PH_S10;
          (op == OP_RTYPE && funct == F_SLT):
            next = PH_S11;
          (op == OP_RTYPE && funct == F_JR):
            next = PH_S12;
          (op == OP_ORI):  next = PH_S13;
          (op == OP_LUI):  next = PH_S14;
          (op == OP_ADDI): next = PH_S19;
          (op == OP_BEQ):  next = PH_S8;
          (op == OP_J):    next = PH_S15;
          (op == OP_JAL):  next = PH_S9;
          default: begin
            illegal = 1'b1;
            next    = PH_IDLE;
          end
        endcase
      end
      // Only memory ops reach S2, so lw is the fallback.
      PH_S2: begin
        unique case (1'b1)
          (op == OP_LB): next = PH_S16;
          (op == OP_SW): next = PH_S5;
          (op == OP_SB): next = PH_S17;
          default:       next = PH_S3;
        endcase
      end
      PH_S3, PH_S16:         next = PH_S4;
      PH_S6, PH_S10, PH_S11: next = PH_S7;
      PH_S13, PH_S14,
      PH_S19:                next = PH_S18;
      default: begin
        if (last)
          next = go ? PH_S0 : PH_IDLE;
        else
          next = PH_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mc_state_seq.sv
// Multi-cycle MIPS32 control sequencer: phase register, err, instret.
// Ports: clk, rst_n, run, op, funct in; state, busy, retire, err, instret out.
module mc_state_seq
  import mc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  output logic [4:0]           state,
  output logic                 busy,
  output logic                 retire,
  output logic                 err,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [INSTRET_W-1:0] ONE =
    {{(INSTRET_W-1){1'b0}}, 1'b1};

  phase_t phase;
  phase_t next;
  logic   illegal;
  logic   last;
  logic   go;

  // A trapped core must not start again until reset.
  assign go = run & ~err;

  mc_next_state u_next (
    .phase   (phase),
    .op      (op),
    .funct   (funct),
    .go      (go),
    .next    (next),
    .illegal (illegal),
    .last    (last)
  );

  assign retire = last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= PH_IDLE;
      state   <= S1;
      busy    <= 1'b0;
      err     <= 1'b0;
      instret <= '0;
    end else begin
      phase <= next;
      // Idle presents the decode code so all enables stay off.
      state <= (next == PH_IDLE) ? S1 : next;
      busy  <= (next != PH_IDLE);
      if (illegal)
        err <= 1'b1;
      if (last)
        instret <= instret + ONE;
    end
  end

endmodule
